// File: rtl/cp0_pkg.sv
// ============================================================================
// Module   : cp0_pkg
// Brief    : Shared CP0 definitions: ExcCodes, register indices, status bits,
//            exception-scheduler FSM states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ERET = 5'h11;

  localparam int CP0_BADVADDR = 8;
  localparam int CP0_STATUS   = 12;
  localparam int CP0_CAUSE    = 13;
  localparam int CP0_EPC      = 14;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_e;

endpackage

`default_nettype wire

// File: rtl/exc_prio_enc.sv
// ============================================================================
// Module   : exc_prio_enc
// Brief    : Combinational priority encoder {int_p, mem_exc, mem_eret} -> ExcCode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_prio_enc
  import cp0_pkg::*;
(
  input  logic       int_p,
  input  logic [6:0] mem_exc,   // {ades, adel, ov, bp, sys, ri, adel_if}
  input  logic       mem_eret,
  output logic [4:0] exccode
);

  always_comb begin
    exccode = EXC_NONE;
    if (int_p)           exccode = EXC_INT;
    else if (mem_exc[0]) exccode = EXC_ADEL;
    else if (mem_exc[1]) exccode = EXC_RI;
    else if (mem_exc[2]) exccode = EXC_SYS;
    else if (mem_exc[3]) exccode = EXC_BP;
    else if (mem_exc[4]) exccode = EXC_OV;
    else if (mem_exc[5]) exccode = EXC_ADEL;
    else if (mem_exc[6]) exccode = EXC_ADES;
    else if (mem_eret)   exccode = EXC_ERET;
  end

endmodule

`default_nettype wire

// File: rtl/exc_ctrl.sv
// ============================================================================
// Module   : exc_ctrl
// Brief    : Commit-point exception scheduler: arbitration, flush/redirect
//            sequencing and stall arbitration. Optional event counters are
//            enabled by defining EXC_CTRL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_ctrl
  import cp0_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int NSTG         = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic [31:0]     mem_pc,
  input  logic            mem_in_delay,
  input  logic [6:0]      mem_exc,
  input  logic            mem_eret,
  input  logic [31:0]     status_i,
  input  logic [31:0]     cause_i,
  input  logic [31:0]     cp0_excaddr,
  input  logic            stallreq_id,
  input  logic            stallreq_ex,
  output logic [4:0]      exccode_o,
  output logic [31:0]     pc_o,
  output logic            in_delay_o,
  output logic            flush_o,
  output logic [NSTG-1:0] stall_o,
  output logic            redirect_valid,
  output logic [31:0]     redirect_pc,
`ifdef EXC_CTRL_CNT_EN
  output logic [31:0]     exc_cnt,
  output logic [31:0]     int_cnt,
`endif
  output logic            busy
);

  localparam int              CNT_W    = 3;
  localparam logic [NSTG-1:0] STALL_EX = NSTG'(4'b1111);
  localparam logic [NSTG-1:0] STALL_ID = NSTG'(3'b111);

  exc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       int_p;
  logic [4:0] prio_code;
  logic       commit_active;
  logic       take;
  logic       unused_status_bits;

  assign int_p = status_i[STATUS_IE] & ~status_i[STATUS_EXL]
               & (|(cause_i[15:10] & status_i[15:10]));
  assign unused_status_bits = ^{status_i[31:16], status_i[9:2], cause_i[31:16], cause_i[9:0]};

  exc_prio_enc u_prio (
    .int_p    (int_p),
    .mem_exc  (mem_exc),
    .mem_eret (mem_eret),
    .exccode  (prio_code)
  );

  assign commit_active = (state_q == ST_IDLE) && mem_valid;
  assign exccode_o     = commit_active ? prio_code : EXC_NONE;
  assign pc_o          = commit_active ? mem_pc : 32'h0;
  assign in_delay_o    = commit_active ? mem_in_delay : 1'b0;
  assign take          = (exccode_o != EXC_NONE);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    flush_o        = 1'b0;
    stall_o        = '0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          // A committing exception preempts any stall request.
          flush_o = 1'b1;
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end else if (stallreq_ex) begin
          stall_o = STALL_EX;
        end else if (stallreq_id) begin
          stall_o = STALL_ID;
        end
      end
      ST_FLUSH: begin
        flush_o = 1'b1;
        stall_o = '1;
        if (cnt_q == '0) state_d = ST_REDIRECT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_REDIRECT: begin
        // CP0 has latched the handler/EPC target by now.
        redirect_valid = 1'b1;
        redirect_pc    = cp0_excaddr;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

`ifdef EXC_CTRL_CNT_EN
  logic [31:0] exc_cnt_q, exc_cnt_d;
  logic [31:0] int_cnt_q, int_cnt_d;

  always_comb begin
    exc_cnt_d = exc_cnt_q;
    int_cnt_d = int_cnt_q;
    if (take && exccode_o != EXC_ERET) exc_cnt_d = exc_cnt_q + 32'd1;
    if (take && exccode_o == EXC_INT)  int_cnt_d = int_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_cnt_q <= '0;
      int_cnt_q <= '0;
    end else begin
      exc_cnt_q <= exc_cnt_d;
      int_cnt_q <= int_cnt_d;
    end
  end

  assign exc_cnt = exc_cnt_q;
  assign int_cnt = int_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl.sv
// ============================================================================
// Module   : tb_exc_ctrl
// Brief    : Randomized self-checking bench for exc_ctrl against a
//            cycle-countdown reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exc_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int NSTG         = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_valid;
  logic [31:0]     mem_pc;
  logic            mem_in_delay;
  logic [6:0]      mem_exc;
  logic            mem_eret;
  logic [31:0]     status_i;
  logic [31:0]     cause_i;
  logic [31:0]     cp0_excaddr;
  logic            stallreq_id;
  logic            stallreq_ex;
  logic [4:0]      exccode_o;
  logic [31:0]     pc_o;
  logic            in_delay_o;
  logic            flush_o;
  logic [NSTG-1:0] stall_o;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic            busy;
`ifdef EXC_CTRL_CNT_EN
  logic [31:0]     exc_cnt;
  logic [31:0]     int_cnt;
`endif

  always #5 clk = ~clk;

  exc_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .NSTG(NSTG)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_pc         (mem_pc),
    .mem_in_delay   (mem_in_delay),
    .mem_exc        (mem_exc),
    .mem_eret       (mem_eret),
    .status_i       (status_i),
    .cause_i        (cause_i),
    .cp0_excaddr    (cp0_excaddr),
    .stallreq_id    (stallreq_id),
    .stallreq_ex    (stallreq_ex),
    .exccode_o      (exccode_o),
    .pc_o           (pc_o),
    .in_delay_o     (in_delay_o),
    .flush_o        (flush_o),
    .stall_o        (stall_o),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef EXC_CTRL_CNT_EN
    .exc_cnt        (exc_cnt),
    .int_cnt        (int_cnt),
`endif
    .busy           (busy)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int n_redirects = 0;

  // Model state: cycles left until back in idle (FLUSH_CYCLES flush + 1 redirect).
  int          m_rem = 0;
  logic [31:0] m_tgt = 32'h0;
  logic [31:0] m_exc_cnt = 32'h0;
  logic [31:0] m_int_cnt = 32'h0;
  logic [31:0] epc_val = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Flag bit i (0=adel_if .. 6=ades) ranks above bit i+1.
  function automatic logic [4:0] ref_code(input logic ip, input logic [6:0] e, input logic er);
    logic [4:0] codes [7];
    codes = '{5'h04, 5'h0a, 5'h08, 5'h09, 5'h0c, 5'h04, 5'h05};
    if (ip) return 5'h00;
    for (int i = 0; i < 7; i++)
      if (e[i]) return codes[i];
    return er ? 5'h11 : 5'h10;
  endfunction

  // One clock: check at negedge, advance model at posedge, then feed CP0 target.
  task automatic cycle();
    logic       ip, idle, take;
    logic [4:0] code;
    logic [5:0] exp_stall;
    @(negedge clk);
    ip   = status_i[0] && !status_i[1] && ((cause_i[15:10] & status_i[15:10]) != 6'd0);
    idle = (m_rem == 0);
    code = (idle && mem_valid) ? ref_code(ip, mem_exc, mem_eret) : 5'h10;
    take = (code != 5'h10);
    if (m_rem > 1)        exp_stall = 6'b111111;
    else if (m_rem == 1)  exp_stall = 6'b000000;
    else if (take)        exp_stall = 6'b000000;
    else if (stallreq_ex) exp_stall = 6'b001111;
    else if (stallreq_id) exp_stall = 6'b000111;
    else                  exp_stall = 6'b000000;
    check("exccode",  32'(exccode_o), 32'(code));
    check("pc",       pc_o, (idle && mem_valid) ? mem_pc : 32'h0);
    check("in_delay", 32'(in_delay_o), 32'(idle && mem_valid && mem_in_delay));
    check("flush",    32'(flush_o), 32'(take || m_rem > 1));
    check("stall",    32'(stall_o), 32'(exp_stall));
    check("redir_v",  32'(redirect_valid), 32'(m_rem == 1));
    check("redir_pc", redirect_pc, (m_rem == 1) ? m_tgt : 32'h0);
    check("busy",     32'(busy), 32'(m_rem != 0));
`ifdef EXC_CTRL_CNT_EN
    check("exc_cnt",  exc_cnt, m_exc_cnt);
    check("int_cnt",  int_cnt, m_int_cnt);
`endif
    if (redirect_valid) n_redirects++;
    @(posedge clk);
    if (rst) begin
      m_rem = 0; m_exc_cnt = 0; m_int_cnt = 0;
    end else if (take) begin
      m_rem = FLUSH_CYCLES + 1;
      m_tgt = (code == 5'h11) ? epc_val : (code == 5'h00) ? 32'h40 : 32'h100;
      if (code != 5'h11) m_exc_cnt++;
      if (code == 5'h00) m_int_cnt++;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    #1;
    cp0_excaddr = (m_rem > 0) ? m_tgt : $urandom;
  endtask

  task automatic idle_inputs();
    rst = 0; mem_valid = 0; mem_pc = 0; mem_in_delay = 0; mem_exc = 0; mem_eret = 0;
    status_i = 0; cause_i = 0; stallreq_id = 0; stallreq_ex = 0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < FLUSH_CYCLES + 2; i++) cycle();
  endtask

  initial begin
    int redir_before;
    idle_inputs();
    cp0_excaddr = 0;
    rst = 1;
    @(posedge clk); #1;
    cycle();                // reset state observed with rst still high
    idle_inputs();
    cycle();

    // sys exception at 0x80
    mem_valid = 1; mem_exc = 7'b0000100; mem_pc = 32'h80; mem_in_delay = 1;
    cycle();
    drain();

    // interrupt beats overflow
    status_i = 32'h1000_0401; cause_i = 32'h0000_0400;
    mem_valid = 1; mem_exc = 7'b0010000; mem_pc = 32'h200;
    cycle();
    drain();

    // EXL blocks interrupt; eret proceeds
    epc_val = 32'h0000_1234;
    status_i = 32'h1000_0403; cause_i = 32'h0000_0400;
    mem_valid = 1; mem_eret = 1; mem_pc = 32'h300;
    cycle();
    drain();

    // stall arbitration, then ri overrides
    stallreq_ex = 1; stallreq_id = 1; mem_valid = 1; mem_pc = 32'h400;
    cycle();
    stallreq_ex = 0;
    cycle();
    stallreq_ex = 1; mem_exc = 7'b0000010;
    cycle();
    drain();

    // second sys during FLUSH is ignored: exactly one redirect
    redir_before = n_redirects;
    mem_valid = 1; mem_exc = 7'b0000100; mem_pc = 32'h500;
    for (int i = 0; i < FLUSH_CYCLES + 2; i++) cycle();
    idle_inputs();
    cycle();
    check("one_redirect", 32'(n_redirects - redir_before), 32'd1);

    // reset in second FLUSH cycle: no redirect
    redir_before = n_redirects;
    mem_valid = 1; mem_exc = 7'b0000100; mem_pc = 32'h600;
    cycle();
    idle_inputs();
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    for (int i = 0; i < 3; i++) cycle();
    check("no_redirect", 32'(n_redirects - redir_before), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 59) == 0);
      mem_valid    = $urandom_range(0, 1);
      mem_pc       = $urandom;
      mem_in_delay = $urandom_range(0, 1);
      for (int b = 0; b < 7; b++) mem_exc[b] = ($urandom_range(0, 9) == 0);
      mem_eret     = ($urandom_range(0, 6) == 0);
      status_i     = $urandom;
      cause_i      = $urandom & (($urandom_range(0, 2) == 0) ? 32'hffff_ffff : 32'hffff_03ff);
      stallreq_id  = $urandom_range(0, 1);
      stallreq_ex  = ($urandom_range(0, 3) == 0);
      epc_val      = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Commit-point exception scheduler for the CP0 register block.
- Collects per-instruction exception flags and eret from the MEM stage, samples pending interrupts from CP0 status/cause, and arbitrates one event per commit.
- Drives the exccode/pc/in_delay inputs of CP0.
- Sequences pipeline flush and PC redirect, and arbitrates stage stall requests.

Parameters:
- FLUSH_CYCLES, 2, cycles held in FLUSH before redirect (1..7).
- NSTG, 6, number of pipeline stall lanes (PC, IF, ID, EX, MEM, WB).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- mem_valid  in  1  instruction at MEM is committing this cycle.
- mem_pc  in  32  PC of the MEM instruction.
- mem_in_delay  in  1  MEM instruction is in a branch delay slot.
- mem_exc  in  7  flags, bit order {ades, adel, ov, bp, sys, ri, adel_if}.
- mem_eret  in  1  MEM instruction is eret.
- status_i  in  32  CP0 status (bit0 IE, bit1 EXL, [15:10] IM).
- cause_i  in  32  CP0 cause ([15:10] IP).
- cp0_excaddr  in  32  handler/EPC target registered by CP0.
- stallreq_id  in  1  ID stall request.
- stallreq_ex  in  1  EX stall request (multi-cycle divide).
- exccode_o  out  5  to CP0. 5'h10 = none, 5'h11 = eret, otherwise MIPS ExcCode.
- pc_o  out  32  to CP0 pc_i.
- in_delay_o  out  1  to CP0 in_delay_i.
- flush_o  out  1  flush all stages.
- stall_o  out  NSTG  per-stage stall, bit0 = PC.
- redirect_valid  out  1  single-cycle strobe; load redirect_pc into PC.
- redirect_pc  out  32  new fetch address.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: exccode_o=5'h10; pc_o=0; in_delay_o=0; flush_o=0; stall_o=0; redirect_valid=0; redirect_pc=0; busy=0; FSM=IDLE; counter=0.
- Interrupt pending: int_p = IE & ~EXL & |(cause_i[15:10] & status_i[15:10]).
- Arbitration is combinational, IDLE and mem_valid only. Priority highest first:
  - int_p → 0x00
  - adel_if → 0x04
  - ri → 0x0a
  - sys → 0x08
  - bp → 0x09
  - ov → 0x0c
  - adel → 0x04
  - ades → 0x05
  - mem_eret → 0x11
  - none → 0x10
- exccode_o/pc_o/in_delay_o are combinational from the arbiter. They are forced to 5'h10/0/0 when not IDLE or when mem_valid=0.
- FSM states: IDLE, FLUSH, REDIRECT.
  - IDLE → FLUSH when the arbiter result ≠ 0x10. Same cycle: flush_o=1 (combinational). Counter loads FLUSH_CYCLES-1.
  - FLUSH: flush_o=1; stall_o all ones; decrement counter. At counter 0 → REDIRECT.
  - REDIRECT: one cycle. redirect_valid=1, redirect_pc=cp0_excaddr (registered by CP0 one cycle after the commit, stable since). flush_o=0. → IDLE.
- Events arriving while busy are ignored. The pipeline is flushed, so mem_valid is don't-care.
- Stall arbitration, IDLE only:
  - stallreq_ex → stall_o=6'b001111.
  - else stallreq_id → 6'b000111.
  - else 0.
  - An exception commit in the same cycle overrides: stall_o=0, flush_o=1.
- Simultaneous interrupt and sync exception: interrupt wins; pc_o = mem_pc (the instruction is re-executed after eret).
- eret while an interrupt is pending: interrupt is not taken because EXL=1 blocks int_p. eret proceeds.
- rst asserted mid-FLUSH: next cycle IDLE with all outputs at reset values; no redirect issued.

Optional Feature:
- Macro EXC_CTRL_CNT_EN.
- Defined: adds outputs exc_cnt (32) and int_cnt (32).
  - exc_cnt increments on every IDLE→FLUSH transition except eret.
  - int_cnt increments when the winner is 0x00.
  - Both wrap at 2^32 and clear on rst.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package (cp0_pkg): ExcCode constants EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_NONE=5'h10, EXC_ERET=5'h11; CP0 register indices 8/12/13/14; status bit positions IE=0, EXL=1; FSM state typedef.
- One natural sub-module: exc_prio_enc, the purely combinational priority encoder from {int_p, mem_exc, mem_eret} to exccode.

Test Plan:
- mem_valid=1, mem_exc=7'b0000100 (sys), mem_pc=0x80, EXL=0 → exccode_o=0x08 and flush_o=1 that cycle. FLUSH lasts 2 cycles. Then redirect_valid=1 with redirect_pc=0x100.
- status=0x1000_0401 (IE, IM0), cause_i[10]=1, mem_exc=ov, mem_pc=0x200 → exccode_o=0x00, pc_o=0x200, redirect_pc=0x040.
- Same interrupt setup but EXL=1 → no interrupt taken. mem_eret=1 → exccode_o=0x11, redirect_pc equals the epc value presented on cp0_excaddr.
- stallreq_ex=1, stallreq_id=1, no exception → stall_o=6'b001111. Add ri in the same cycle → stall_o=0, flush_o=1, exccode_o=0x0a.
- A second sys exception presented during FLUSH → ignored; exccode_o=0x10 and exactly one redirect pulse.
- rst=1 in the second FLUSH cycle → next cycle busy=0, flush_o=0, redirect_valid never asserted. With EXC_CTRL_CNT_EN, exc_cnt=0.
